// File: rtl/fric_pkg.sv
// Shared constants and types for the fric master-port arbiter.
package fric_pkg;

    // Command types understood by fric_client_master
    localparam logic [3:0] CTYP_WRITE = 4'h0;
    localparam logic [3:0] CTYP_READ  = 4'h2;

    // Arbiter FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT_RD = 2'd2;

    // Read data substituted when the read-reply watchdog fires
    localparam logic [15:0] FRIC_ERR_RDAT = 16'hDEAD;

    // One captured command as presented to the master port
    typedef struct packed {
        logic [3:0]  ctyp;
        logic [3:0]  port;
        logic [7:0]  addr;
        logic [15:0] wdat;
    } fric_cmd_t;

endpackage

// File: rtl/fric_master_arbiter_if.sv
// Command/reply bus between the arbiter and the fric_client_master instance.
interface fric_master_arbiter_if;
    logic [3:0]  m_ctyp;
    logic [3:0]  m_port;
    logic [7:0]  m_addr;
    logic [15:0] m_wdat;
    logic        m_tstb;
    logic        m_trdy;
    logic        m_rstb;
    logic [15:0] m_rdat;

    // The arbiter side issues commands and receives replies
    modport master (
        output m_ctyp, m_port, m_addr, m_wdat, m_tstb,
        input  m_trdy, m_rstb, m_rdat
    );

    // The client-master side accepts commands and returns replies
    modport slave (
        input  m_ctyp, m_port, m_addr, m_wdat, m_tstb,
        output m_trdy, m_rstb, m_rdat
    );
endinterface

// File: rtl/fric_rr_arbiter.sv
// Combinational round-robin search: first request strictly above ptr, wrapping.
module fric_rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [2:0]       idx
);
    logic [N_REQ-1:0] upper_mask;
    logic [N_REQ-1:0] upper_req;
    logic [N_REQ-1:0] sel_req;
    logic [2:0]       enc [N_REQ];

    // Positions above the last winner get first look
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
        assign upper_mask[gi] = (3'(gi) > ptr);
        assign enc[gi]        = gnt[gi] ? 3'(gi) : 3'd0;
    end

    assign upper_req = req & upper_mask;
    assign sel_req   = (|upper_req) ? upper_req : req;
    // Isolate the lowest set bit of the selected request set
    assign gnt       = sel_req & (~sel_req + 1'b1);

    // Encode the one-hot grant into an index
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = idx | enc[i];
        end
    end
endmodule

// File: rtl/fric_master_arbiter.sv
// Round-robin sharing of one fric_client_master port between N_REQ requesters.
// Grant is held through command acceptance and, for reads, until the reply.
// Optional read-reply watchdog: define FRIC_ARB_TIMEOUT_EN.
module fric_master_arbiter
    import fric_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     rq_valid,
    output logic [N_REQ-1:0]     rq_ready,
    input  logic [4*N_REQ-1:0]   rq_ctyp,
    input  logic [4*N_REQ-1:0]   rq_port,
    input  logic [8*N_REQ-1:0]   rq_addr,
    input  logic [16*N_REQ-1:0]  rq_wdat,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [15:0]          rsp_rdat,
    output logic                 rsp_err,
    fric_master_arbiter_if.master m,
    output logic                 busy,
    output logic [2:0]           owner
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    fric_cmd_t        cmd_arr [N_REQ];
    logic [N_REQ-1:0] win_gnt;
    logic [2:0]       win_idx;

    logic [1:0]       state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       owner_q, owner_d;
    fric_cmd_t        cmd_q, cmd_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [15:0]      rsp_rdat_q, rsp_rdat_d;

`ifdef FRIC_ARB_TIMEOUT_EN
    logic             rsp_err_q, rsp_err_d;
    logic [15:0]      wd_cnt_q, wd_cnt_d;
    logic             wd_expired;
    assign wd_expired = (wd_cnt_q == 16'(TIMEOUT_CYCLES));
    assign rsp_err    = rsp_err_q;
`else
    logic [15:0]      unused_timeout;
    assign unused_timeout = 16'(TIMEOUT_CYCLES);
    assign rsp_err        = 1'b0;
`endif

    // Unpack each requester's command fields
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_fields
        assign cmd_arr[gi] = {rq_ctyp[gi*4 +: 4], rq_port[gi*4 +: 4],
                              rq_addr[gi*8 +: 8], rq_wdat[gi*16 +: 16]};
    end

    fric_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req (rq_valid),
        .ptr (ptr_q),
        .gnt (win_gnt),
        .idx (win_idx)
    );

    // Next-state, grant capture and reply generation
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cmd_d       = cmd_q;
        rsp_valid_d = '0;
        rsp_rdat_d  = rsp_rdat_q;
`ifdef FRIC_ARB_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
        wd_cnt_d    = wd_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|win_gnt) begin
                    cmd_d   = cmd_arr[win_idx[IDX_W-1:0]];
                    ptr_d   = win_idx;
                    owner_d = win_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (m.m_trdy) begin
                    state_d = (cmd_q.ctyp == CTYP_READ) ? ST_WAIT_RD : ST_IDLE;
`ifdef FRIC_ARB_TIMEOUT_EN
                    wd_cnt_d = '0;
`endif
                end
            end
            ST_WAIT_RD: begin
                // A real reply beats the watchdog when both land together
                if (m.m_rstb) begin
                    rsp_rdat_d                     = m.m_rdat;
                    rsp_valid_d[owner_q[IDX_W-1:0]] = 1'b1;
`ifdef FRIC_ARB_TIMEOUT_EN
                    rsp_err_d                      = 1'b0;
`endif
                    state_d                        = ST_IDLE;
                end
`ifdef FRIC_ARB_TIMEOUT_EN
                else if (wd_expired) begin
                    rsp_rdat_d                     = FRIC_ERR_RDAT;
                    rsp_valid_d[owner_q[IDX_W-1:0]] = 1'b1;
                    rsp_err_d                      = 1'b1;
                    state_d                        = ST_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset aborts any transaction without a reply
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 3'(N_REQ - 1);
            owner_q     <= '0;
            cmd_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdat_q  <= '0;
`ifdef FRIC_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
            wd_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cmd_q       <= cmd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdat_q  <= rsp_rdat_d;
`ifdef FRIC_ARB_TIMEOUT_EN
            rsp_err_q   <= rsp_err_d;
            wd_cnt_q    <= wd_cnt_d;
`endif
        end
    end

    // Accept is only offered while idle, and never during reset
    assign rq_ready  = ((state_q == ST_IDLE) && !rst) ? win_gnt : '0;
    assign m.m_ctyp  = cmd_q.ctyp;
    assign m.m_port  = cmd_q.port;
    assign m.m_addr  = cmd_q.addr;
    assign m.m_wdat  = cmd_q.wdat;
    assign m.m_tstb  = (state_q == ST_ISSUE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdat  = rsp_rdat_q;
    assign busy      = (state_q != ST_IDLE);
    assign owner     = owner_q;
endmodule

// File: tb/tb_fric_master_arbiter.sv
// Self-checking bench for fric_master_arbiter with command/reply scoreboards.
module tb_fric_master_arbiter;
    import fric_pkg::*;

    localparam int N = 4;
`ifdef FRIC_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 1023;
`endif

    typedef struct packed {
        logic [2:0]  owner;
        logic [3:0]  ctyp;
        logic [3:0]  port;
        logic [7:0]  addr;
        logic [15:0] wdat;
    } exp_cmd_t;

    typedef struct packed {
        logic [N-1:0] valid;
        logic [15:0]  rdat;
        logic         err;
    } exp_rsp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    rq_valid, rq_ready, rsp_valid;
    logic [4*N-1:0]  rq_ctyp, rq_port;
    logic [8*N-1:0]  rq_addr;
    logic [16*N-1:0] rq_wdat;
    logic [15:0]     rsp_rdat;
    logic            rsp_err, busy;
    logic [2:0]      owner;

    exp_cmd_t exp_cmd_q[$];
    exp_rsp_t exp_rsp_q[$];
    exp_cmd_t mon_c;
    exp_rsp_t mon_r;
    int n_compared   = 0;
    int n_mismatched = 0;

    fric_master_arbiter_if m_if();

    always #5 clk = ~clk;

    fric_master_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .rq_valid(rq_valid), .rq_ready(rq_ready),
        .rq_ctyp(rq_ctyp), .rq_port(rq_port), .rq_addr(rq_addr), .rq_wdat(rq_wdat),
        .rsp_valid(rsp_valid), .rsp_rdat(rsp_rdat), .rsp_err(rsp_err),
        .m(m_if), .busy(busy), .owner(owner)
    );

    // Scoreboard monitor: every master transfer and every reply is matched in order
    always @(negedge clk) begin
        if (!rst && m_if.m_tstb && m_if.m_trdy) begin
            n_compared++;
            if (exp_cmd_q.size() == 0) begin
                n_mismatched++;
                $display("FAIL cmd_unexpected: got owner=%0d ctyp=%h addr=%h, want no transfer",
                         owner, m_if.m_ctyp, m_if.m_addr);
            end else begin
                mon_c = exp_cmd_q.pop_front();
                if ({owner, m_if.m_ctyp, m_if.m_port, m_if.m_addr, m_if.m_wdat} !== mon_c) begin
                    n_mismatched++;
                    $display("FAIL cmd_fields: got %h, want %h",
                             {owner, m_if.m_ctyp, m_if.m_port, m_if.m_addr, m_if.m_wdat}, mon_c);
                end else
                    $display("cmd  owner=%0d ctyp=%h port=%h addr=%h wdat=%h",
                             owner, m_if.m_ctyp, m_if.m_port, m_if.m_addr, m_if.m_wdat);
            end
        end
        if (!rst && rsp_valid !== '0) begin
            n_compared++;
            if (exp_rsp_q.size() == 0) begin
                n_mismatched++;
                $display("FAIL rsp_unexpected: got rsp_valid=%b, want none", rsp_valid);
            end else begin
                mon_r = exp_rsp_q.pop_front();
                if ({rsp_valid, rsp_rdat, rsp_err} !== mon_r) begin
                    n_mismatched++;
                    $display("FAIL rsp_fields: got %h, want %h", {rsp_valid, rsp_rdat, rsp_err}, mon_r);
                end else
                    $display("rsp  valid=%b rdat=%h err=%b", rsp_valid, rsp_rdat, rsp_err);
            end
        end
    end

    task automatic set_req(input int i, input logic [3:0] ctyp, input logic [3:0] port,
                           input logic [7:0] addr, input logic [15:0] wdat);
        rq_ctyp[i*4 +: 4]   = ctyp;
        rq_port[i*4 +: 4]   = port;
        rq_addr[i*8 +: 8]   = addr;
        rq_wdat[i*16 +: 16] = wdat;
        rq_valid[i]         = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_compared++;
        if ({busy, m_if.m_tstb, rsp_valid, owner, rq_ready, rsp_err} !== '0) begin
            n_mismatched++;
            $display("FAIL reset_ctrl: got busy=%b tstb=%b rsp_valid=%b owner=%0d ready=%b err=%b, want all 0",
                     busy, m_if.m_tstb, rsp_valid, owner, rq_ready, rsp_err);
        end
        n_compared++;
        if ({m_if.m_ctyp, m_if.m_port, m_if.m_addr, m_if.m_wdat, rsp_rdat} !== '0) begin
            n_mismatched++;
            $display("FAIL reset_data: got %h, want 0",
                     {m_if.m_ctyp, m_if.m_port, m_if.m_addr, m_if.m_wdat, rsp_rdat});
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        @(posedge clk); #1;
        m_if.m_trdy = 1'b1;
        set_req(0, CTYP_WRITE, 4'h1, 8'h10, 16'hA5A5);
        exp_cmd_q.push_back({3'd0, CTYP_WRITE, 4'h1, 8'h10, 16'hA5A5});
        @(negedge clk);
        n_compared++;
        if (rq_ready !== 4'b0001) begin
            n_mismatched++;
            $display("FAIL write_ready: got %b, want 0001", rq_ready);
        end
        @(posedge clk); #1;
        rq_valid = '0;
        @(negedge clk);
        n_compared++;
        if ({m_if.m_tstb, busy} !== 2'b11) begin
            n_mismatched++;
            $display("FAIL write_issue: got tstb=%b busy=%b, want 1 1", m_if.m_tstb, busy);
        end
        @(negedge clk);
        n_compared++;
        if ({m_if.m_tstb, busy} !== 2'b00) begin
            n_mismatched++;
            $display("FAIL write_done: got tstb=%b busy=%b, want 0 0", m_if.m_tstb, busy);
        end
    endtask

    task automatic test_read();
        @(posedge clk); #1;
        m_if.m_trdy = 1'b1;
        set_req(2, CTYP_READ, 4'h3, 8'h20, 16'h0000);
        exp_cmd_q.push_back({3'd2, CTYP_READ, 4'h3, 8'h20, 16'h0000});
        @(negedge clk);
        n_compared++;
        if (rq_ready !== 4'b0100) begin
            n_mismatched++;
            $display("FAIL read_ready: got %b, want 0100", rq_ready);
        end
        @(posedge clk); #1;
        rq_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        n_compared++;
        if ({busy, m_if.m_tstb, owner} !== {1'b1, 1'b0, 3'd2}) begin
            n_mismatched++;
            $display("FAIL read_wait: got busy=%b tstb=%b owner=%0d, want 1 0 2", busy, m_if.m_tstb, owner);
        end
        repeat (3) @(posedge clk);
        #1;
        m_if.m_rstb = 1'b1;
        m_if.m_rdat = 16'h1234;
        exp_rsp_q.push_back({4'b0100, 16'h1234, 1'b0});
        @(posedge clk); #1;
        m_if.m_rstb = 1'b0;
        m_if.m_rdat = 16'h0000;
        @(negedge clk);
        n_compared++;
        if (busy !== 1'b0) begin
            n_mismatched++;
            $display("FAIL read_idle: got busy=%b, want 0", busy);
        end
        @(negedge clk);
        n_compared++;
        if (rsp_valid !== 4'b0000) begin
            n_mismatched++;
            $display("FAIL read_pulse: got rsp_valid=%b, want 0000", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_if.m_trdy = 1'b1;
        for (int i = 0; i < N; i++)
            set_req(i, CTYP_WRITE, 4'(i), 8'(8'h40 + i), 16'(16'h1000 * (i + 1)));
        for (int k = 0; k < 5; k++)
            exp_cmd_q.push_back({3'(k % N), CTYP_WRITE, 4'(k % N), 8'(8'h40 + k % N),
                                 16'(16'h1000 * (k % N + 1))});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp_g = '0;
            exp_g[k % N] = 1'b1;
            n_compared++;
            if (rq_ready !== exp_g) begin
                n_mismatched++;
                $display("FAIL rr_grant%0d: got %b, want %b", k, rq_ready, exp_g);
            end
            if (k == 4) begin
                @(posedge clk); #1;
                rq_valid = '0;
            end
            @(negedge clk);
            n_compared++;
            if (rq_ready !== '0) begin
                n_mismatched++;
                $display("FAIL rr_issue_ready%0d: got %b, want 0000", k, rq_ready);
            end
        end
        @(negedge clk);
        n_compared++;
        if (busy !== 1'b0) begin
            n_mismatched++;
            $display("FAIL rr_idle: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_backpressure();
        int ready_cnt;
        ready_cnt = 0;
        @(posedge clk); #1;
        m_if.m_trdy = 1'b0;
        set_req(1, CTYP_WRITE, 4'h5, 8'h33, 16'hBEEF);
        exp_cmd_q.push_back({3'd1, CTYP_WRITE, 4'h5, 8'h33, 16'hBEEF});
        @(negedge clk);
        if (rq_ready[1]) ready_cnt++;
        @(posedge clk); #1;
        rq_valid = '0;
        m_if.m_rstb = 1'b1;
        m_if.m_rdat = 16'h7777;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rq_ready[1]) ready_cnt++;
            n_compared++;
            if ({m_if.m_tstb, owner, m_if.m_ctyp, m_if.m_port, m_if.m_addr, m_if.m_wdat}
                !== {1'b1, 3'd1, CTYP_WRITE, 4'h5, 8'h33, 16'hBEEF}) begin
                n_mismatched++;
                $display("FAIL bp_hold%0d: got tstb=%b owner=%0d fields=%h, want 1 1 0533beef", c,
                         m_if.m_tstb, owner, {m_if.m_ctyp, m_if.m_port, m_if.m_addr, m_if.m_wdat});
            end
            @(posedge clk); #1;
            m_if.m_rstb = 1'b0;
            if (c == 2) m_if.m_trdy = 1'b1;
        end
        @(negedge clk);
        if (rq_ready[1]) ready_cnt++;
        @(negedge clk);
        if (rq_ready[1]) ready_cnt++;
        n_compared++;
        if ({busy, m_if.m_tstb} !== 2'b00) begin
            n_mismatched++;
            $display("FAIL bp_done: got busy=%b tstb=%b, want 0 0", busy, m_if.m_tstb);
        end
        n_compared++;
        if (ready_cnt !== 1) begin
            n_mismatched++;
            $display("FAIL bp_ready_pulses: got %0d, want 1", ready_cnt);
        end
    endtask

    task automatic test_reset_mid_read();
        @(posedge clk); #1;
        m_if.m_trdy = 1'b1;
        set_req(1, CTYP_READ, 4'h2, 8'h7E, 16'h0000);
        exp_cmd_q.push_back({3'd1, CTYP_READ, 4'h2, 8'h7E, 16'h0000});
        @(posedge clk); #1;
        rq_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        n_compared++;
        if ({busy, m_if.m_tstb} !== 2'b10) begin
            n_mismatched++;
            $display("FAIL rmr_wait: got busy=%b tstb=%b, want 1 0", busy, m_if.m_tstb);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_compared++;
        if ({busy, m_if.m_tstb, rsp_valid} !== '0) begin
            n_mismatched++;
            $display("FAIL rmr_after: got busy=%b tstb=%b rsp_valid=%b, want 0 0 0000",
                     busy, m_if.m_tstb, rsp_valid);
        end
        @(posedge clk); #1;
        m_if.m_rstb = 1'b1;
        m_if.m_rdat = 16'h5555;
        @(posedge clk); #1;
        m_if.m_rstb = 1'b0;
        @(negedge clk);
        n_compared++;
        if (rsp_valid !== 4'b0000) begin
            n_mismatched++;
            $display("FAIL rmr_stray: got rsp_valid=%b, want 0000", rsp_valid);
        end
        @(posedge clk); #1;
        set_req(2, CTYP_WRITE, 4'h9, 8'h02, 16'h2222);
        set_req(0, CTYP_WRITE, 4'h8, 8'h01, 16'h1111);
        exp_cmd_q.push_back({3'd0, CTYP_WRITE, 4'h8, 8'h01, 16'h1111});
        @(negedge clk);
        n_compared++;
        if (rq_ready !== 4'b0001) begin
            n_mismatched++;
            $display("FAIL rmr_regrant: got %b, want 0001", rq_ready);
        end
        @(posedge clk); #1;
        rq_valid = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

`ifdef FRIC_ARB_TIMEOUT_EN
    task automatic test_timeout();
        @(posedge clk); #1;
        m_if.m_trdy = 1'b1;
        set_req(2, CTYP_READ, 4'h1, 8'h99, 16'h0000);
        exp_cmd_q.push_back({3'd2, CTYP_READ, 4'h1, 8'h99, 16'h0000});
        exp_rsp_q.push_back({4'b0100, FRIC_ERR_RDAT, 1'b1});
        @(posedge clk); #1;
        rq_valid = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (exp_rsp_q.size() == 0) break;
        end
        n_compared++;
        if (exp_rsp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL timeout_reply: got no reply after 40 cycles, want DEAD reply");
        end
        @(negedge clk);
        n_compared++;
        if ({busy, rsp_valid} !== '0) begin
            n_mismatched++;
            $display("FAIL timeout_idle: got busy=%b rsp_valid=%b, want 0 0000", busy, rsp_valid);
        end
    endtask
`endif

    initial begin
        rst         = 1'b1;
        rq_valid    = '0;
        rq_ctyp     = '0;
        rq_port     = '0;
        rq_addr     = '0;
        rq_wdat     = '0;
        m_if.m_trdy = 1'b0;
        m_if.m_rstb = 1'b0;
        m_if.m_rdat = '0;

        test_reset();
        test_single_write();
        test_read();
        test_round_robin();
        test_backpressure();
        test_reset_mid_read();
`ifdef FRIC_ARB_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(negedge clk);
        n_compared++;
        if (exp_cmd_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL cmd_drain: got %0d pending, want 0", exp_cmd_q.size());
        end
        n_compared++;
        if (exp_rsp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL rsp_drain: got %0d pending, want 0", exp_rsp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
